// File: rtl/branch_predict_unit_pkg.sv
// Shared branch-predictor types: branch type encoding, prediction and resolution records,
// table depths and the 2-bit saturating counter update.
package branch_predict_unit_pkg;

  localparam int BHT_ENTRIES = 256;
  localparam int BTB_ENTRIES = 64;
  localparam int RAS_DEPTH   = 8;

  typedef enum logic [1:0] {
    BT_BR   = 2'd0,
    BT_J    = 2'd1,
    BT_CALL = 2'd2,
    BT_RET  = 2'd3
  } branch_type_e;

  typedef struct packed {
    logic         valid;
    branch_type_e btype;
    logic         taken;
    logic [31:0]  target;
  } presult_t;

  typedef struct packed {
    logic         valid;
    logic [31:0]  pc;
    branch_type_e btype;
    logic         taken;
    logic [31:0]  target;
  } bresult_t;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      if (cnt == 2'b11) res = cnt;
      else              res = cnt + 2'b01;
    end else begin
      if (cnt == 2'b00) res = cnt;
      else              res = cnt - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch/execute-side connection of the branch predictor: lookup request, registered
// prediction, stall, resolved-branch feedback and mispredict flush.
interface branch_predict_unit_if;
  import branch_predict_unit_pkg::*;

  logic [31:0] PF_PC;
  logic        PF_Req;
  logic        IF_Stall;
  presult_t    IF_PResult;
  bresult_t    EXE_BResult;
  logic        EXE_Prediction_Failed;

  modport master (
    output PF_PC, PF_Req, IF_Stall, EXE_BResult, EXE_Prediction_Failed,
    input  IF_PResult
  );

  modport slave (
    input  PF_PC, PF_Req, IF_Stall, EXE_BResult, EXE_Prediction_Failed,
    output IF_PResult
  );

endinterface

// File: rtl/branch_predict_unit_ras.sv
// Return-address stack with a speculative pointer (moved by predictions) and a committed
// pointer (moved by resolved branches). Present only when BPU_RAS_EN is defined.
`ifdef BPU_RAS_EN
module bpu_ras
  import branch_predict_unit_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        spec_push_i,
  input  logic        spec_pop_i,
  input  logic [31:0] push_data_i,
  input  logic        commit_push_i,
  input  logic        commit_pop_i,
  input  logic        restore_i,
  output logic [31:0] top_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      stack_q [DEPTH];
  logic [PTR_W-1:0] spec_ptr_q, spec_ptr_d;
  logic [PTR_W-1:0] commit_ptr_q, commit_ptr_d;
  logic [PTR_W-1:0] top_idx_s;
  logic             stack_we_s;

  // Pointers address the next free slot; wrapping lets overflow overwrite the oldest entry.
  always_comb begin
    commit_ptr_d = commit_ptr_q;
    if (commit_push_i)     commit_ptr_d = commit_ptr_q + PTR_W'(1);
    else if (commit_pop_i) commit_ptr_d = commit_ptr_q - PTR_W'(1);
    else                   commit_ptr_d = commit_ptr_q;

    spec_ptr_d = spec_ptr_q;
    if (restore_i)        spec_ptr_d = commit_ptr_d;
    else if (spec_push_i) spec_ptr_d = spec_ptr_q + PTR_W'(1);
    else if (spec_pop_i)  spec_ptr_d = spec_ptr_q - PTR_W'(1);
    else                  spec_ptr_d = spec_ptr_q;

    stack_we_s = spec_push_i && !restore_i;
    top_idx_s  = spec_ptr_q - PTR_W'(1);
  end

  assign top_o = stack_q[top_idx_s];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spec_ptr_q   <= '0;
      commit_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= 32'h0000_0000;
    end else begin
      spec_ptr_q   <= spec_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      if (stack_we_s) stack_q[spec_ptr_q] <= push_data_i;
    end
  end

endmodule
`endif

// File: rtl/branch_predict_unit.sv
// Fetch-side branch predictor: BHT + direct-mapped BTB lookup registered into IF_PResult,
// trained from EXE_BResult. Define BPU_RAS_EN to add the return-address stack for RET.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  branch_predict_unit_if.slave  bpu
);

  localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);
  localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W     = 32 - BTB_IDX_W - 2;

  logic [1:0]        bht_q        [BHT_ENTRIES];
  logic              btb_valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag_q    [BTB_ENTRIES];
  branch_type_e      btb_type_q   [BTB_ENTRIES];
  logic [31:0]       btb_target_q [BTB_ENTRIES];

  presult_t pres_q, pres_d;
  presult_t lk_res_s;

  logic [BHT_IDX_W-1:0] lk_bht_idx_s, wr_bht_idx_s;
  logic [BTB_IDX_W-1:0] lk_btb_idx_s, wr_btb_idx_s;
  logic [TAG_W-1:0]     lk_tag_s, wr_tag_s;
  logic                 lk_hit_s;
  branch_type_e         lk_type_s;
  logic                 bht_we_s, btb_we_s;
  logic [1:0]           bht_d;
  logic                 unused_s;

  assign lk_bht_idx_s = bpu.PF_PC[BHT_IDX_W+1:2];
  assign lk_btb_idx_s = bpu.PF_PC[BTB_IDX_W+1:2];
  assign lk_tag_s     = bpu.PF_PC[31:BTB_IDX_W+2];
  assign wr_bht_idx_s = bpu.EXE_BResult.pc[BHT_IDX_W+1:2];
  assign wr_btb_idx_s = bpu.EXE_BResult.pc[BTB_IDX_W+1:2];
  assign wr_tag_s     = bpu.EXE_BResult.pc[31:BTB_IDX_W+2];
  assign lk_hit_s     = btb_valid_q[lk_btb_idx_s] && (btb_tag_q[lk_btb_idx_s] == lk_tag_s);
  assign lk_type_s    = btb_type_q[lk_btb_idx_s];
  assign unused_s     = ^{bpu.PF_PC[1:0], bpu.EXE_BResult.pc[1:0]};

`ifdef BPU_RAS_EN
  logic        lk_fire_s;
  logic [31:0] ras_top_s;

  assign lk_fire_s = bpu.PF_Req && !bpu.IF_Stall && !bpu.EXE_Prediction_Failed && lk_hit_s;

  bpu_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk           (clk),
    .resetn        (resetn),
    .spec_push_i   (lk_fire_s && (lk_type_s == BT_CALL)),
    .spec_pop_i    (lk_fire_s && (lk_type_s == BT_RET)),
    .push_data_i   (bpu.PF_PC + 32'd8),
    .commit_push_i (bpu.EXE_BResult.valid && (bpu.EXE_BResult.btype == BT_CALL)),
    .commit_pop_i  (bpu.EXE_BResult.valid && (bpu.EXE_BResult.btype == BT_RET)),
    .restore_i     (bpu.EXE_Prediction_Failed),
    .top_o         (ras_top_s)
  );
`endif

  // Lookup reads the tables before this edge's training write lands (read-before-write).
  always_comb begin
    lk_res_s = '0;
    if (lk_hit_s) begin
      lk_res_s.valid = 1'b1;
      lk_res_s.btype = lk_type_s;
      case (lk_type_s)
        BT_BR:   lk_res_s.taken = bht_q[lk_bht_idx_s][1];
        default: lk_res_s.taken = 1'b1;
      endcase
`ifdef BPU_RAS_EN
      if (lk_type_s == BT_RET) lk_res_s.target = ras_top_s;
      else                     lk_res_s.target = btb_target_q[lk_btb_idx_s];
`else
      lk_res_s.target = btb_target_q[lk_btb_idx_s];
`endif
    end else begin
      lk_res_s = '0;
    end

    pres_d = pres_q;
    if (bpu.EXE_Prediction_Failed) pres_d = '0;
    else if (bpu.IF_Stall)         pres_d = pres_q;
    else if (bpu.PF_Req)           pres_d = lk_res_s;
    else                           pres_d = '0;

    bht_we_s = bpu.EXE_BResult.valid && (bpu.EXE_BResult.btype == BT_BR);
    btb_we_s = bpu.EXE_BResult.valid && bpu.EXE_BResult.taken;
    bht_d    = sat_update(bht_q[wr_bht_idx_s], bpu.EXE_BResult.taken);
  end

  assign bpu.IF_PResult = pres_q;

  // Registered prediction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pres_q <= '0;
    else         pres_q <= pres_d;
  end

  // Counters start weakly not-taken; BTB entries start invalid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid_q[i] <= 1'b0;
    end else begin
      if (bht_we_s) bht_q[wr_bht_idx_s] <= bht_d;
      if (btb_we_s) btb_valid_q[wr_btb_idx_s] <= 1'b1;
    end
  end

  // BTB payload needs no reset: it is only visible behind a valid bit.
  always_ff @(posedge clk) begin
    if (btb_we_s) begin
      btb_tag_q[wr_btb_idx_s]    <= wr_tag_s;
      btb_type_q[wr_btb_idx_s]   <= bpu.EXE_BResult.btype;
      btb_target_q[wr_btb_idx_s] <= bpu.EXE_BResult.target;
    end
  end

endmodule
